// File: rtl/dfr_pkg.sv
// Shared DFR definitions: fixed-point format defaults, sample type and
// the input-masker state encoding.
package dfr_pkg;

  localparam int DFR_DATA_WIDTH = 32;
  localparam int DFR_FRAC_BITS  = 16;

  typedef logic signed [DFR_DATA_WIDTH-1:0] sample_t;

  localparam sample_t SAT_MAX = 32'sh7FFF_FFFF;
  localparam sample_t SAT_MIN = 32'sh8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_SAMPLE = 3'd1,
    ST_EXPAND      = 3'd2,
    ST_DRAIN       = 3'd3,
    ST_DONE        = 3'd4
  } masker_state_e;

endpackage

// File: rtl/dfr_input_masker_if.sv
// Raw sample stream (valid/ready) feeding the input masker.
interface dfr_input_masker_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/dfr_fixed_mul_sat.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift by FRAC_BITS, saturation to the DATA_WIDTH signed range.
module dfr_fixed_mul_sat
  import dfr_pkg::*;
#(
  parameter int DATA_WIDTH = DFR_DATA_WIDTH,
  parameter int FRAC_BITS  = DFR_FRAC_BITS
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] MAX_W = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_W = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PW-1:0] a_ext_s;
  logic signed [PW-1:0] b_ext_s;
  logic signed [PW-1:0] prod_s;
  logic signed [PW-1:0] shift_s;

  // Sign-extend both operands so the low PW bits of the product are exact.
  always_comb begin
    a_ext_s = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    b_ext_s = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    prod_s  = a_ext_s * b_ext_s;
    shift_s = prod_s >>> FRAC_BITS;
    if (shift_s > MAX_W) begin
      y = MAX_V;
    end else if (shift_s < MIN_W) begin
      y = MIN_V;
    end else begin
      y = shift_s[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dfr_input_masker.sv
// DFR input masker: expands each stream sample into NK masked words written
// to input memory. Define DFR_BINARY_MASK_EN for sign-flip (+/-1) masks.
module dfr_input_masker
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = DFR_DATA_WIDTH,
  parameter int FRAC_BITS       = DFR_FRAC_BITS,
  parameter int MASK_ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        num_samples,
  input  logic [ADDR_WIDTH-1:0]        num_steps_per_sample,
  dfr_input_masker_if.slave            s_if,
  output logic [MASK_ADDR_WIDTH-1:0]   mask_addr,
  input  logic signed [DATA_WIDTH-1:0] mask_data,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_din,
  output logic                         mem_wen,
  output logic                         busy,
  output logic                         done
);
  localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  masker_state_e               state_r;
  logic [ADDR_WIDTH-1:0]       ns_r, nk_r, sample_cnt_r, step_r, write_addr_r;
  logic                        drain_r, s_ready_r, busy_r, done_r;
  logic signed [DATA_WIDTH-1:0] sample_r;
  logic signed [DATA_WIDTH-1:0] product_s;
  logic                        v1_r, mem_wen_r;
  logic [ADDR_WIDTH-1:0]       mem_addr_r;
  logic [DATA_WIDTH-1:0]       mem_din_r;

`ifdef DFR_BINARY_MASK_EN
  localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Mask bit 0 picks the sign; negating the most negative value saturates.
  always_comb begin
    if (mask_data[0] == 1'b0) begin
      product_s = sample_r;
    end else if (sample_r == MIN_V) begin
      product_s = MAX_V;
    end else begin
      product_s = -sample_r;
    end
  end
`else
  dfr_fixed_mul_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mul (
    .a (sample_r),
    .b (mask_data),
    .y (product_s)
  );
`endif

  // Control FSM; handshake and status outputs are set together with the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ns_r         <= A_ZERO;
      nk_r         <= A_ZERO;
      sample_cnt_r <= A_ZERO;
      step_r       <= A_ZERO;
      drain_r      <= 1'b0;
      sample_r     <= {DATA_WIDTH{1'b0}};
      s_ready_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            ns_r         <= num_samples;
            nk_r         <= num_steps_per_sample;
            sample_cnt_r <= A_ZERO;
            step_r       <= A_ZERO;
            busy_r       <= 1'b1;
            if ((num_samples == A_ZERO) || (num_steps_per_sample == A_ZERO)) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r   <= ST_WAIT_SAMPLE;
              s_ready_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT_SAMPLE: begin
          if (s_if.s_valid && s_ready_r) begin
            sample_r  <= $signed(s_if.s_data);
            step_r    <= A_ZERO;
            s_ready_r <= 1'b0;
            state_r   <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          step_r <= step_r + A_ONE;
          if (step_r == (nk_r - A_ONE)) begin
            sample_cnt_r <= sample_cnt_r + A_ONE;
            drain_r      <= 1'b0;
            state_r      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Two cycles let the last product leave the read/multiply pipeline.
          if (drain_r) begin
            drain_r <= 1'b0;
            if (sample_cnt_r == ns_r) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r   <= ST_WAIT_SAMPLE;
              s_ready_r <= 1'b1;
            end
          end else begin
            drain_r <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          s_ready_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Write pipeline: v1 marks a valid mask word, the next edge registers the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r         <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= A_ZERO;
      mem_din_r    <= {DATA_WIDTH{1'b0}};
      write_addr_r <= A_ZERO;
    end else begin
      v1_r      <= (state_r == ST_EXPAND);
      mem_wen_r <= v1_r;
      if ((state_r == ST_IDLE) && start) begin
        write_addr_r <= A_ZERO;
      end else if (v1_r) begin
        write_addr_r <= write_addr_r + A_ONE;
      end
      if (v1_r) begin
        mem_din_r  <= product_s;
        mem_addr_r <= write_addr_r;
      end
    end
  end

  assign s_if.s_ready = s_ready_r;
  assign mask_addr    = step_r[MASK_ADDR_WIDTH-1:0];
  assign mem_addr     = mem_addr_r;
  assign mem_din      = mem_din_r;
  assign mem_wen      = mem_wen_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule
